spi_host_fifo: RTL and testbench

Host-side byte sequencer placed directly upstream of the SPI interface block. Buffers outgoing bytes in a TX FIFO and, one at a time, loads each into the interface (write strobe plus data). It then waits for the full-duplex exchange to finish, reads back the received byte, and stores it in an RX FIFO for the host. It turns the interface's single-byte register handshake into a streaming, back-pressured byte pipe with timeout protection.

---
 rtl/spi_host_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_spi_host_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_fifo.sv
// Host-side byte sequencer for the SPI interface block: a TX FIFO feeds single-byte
// exchanges and each received byte is stored in an RX FIFO, with timeout protection.
module spi_host_fifo #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          WR_EN,
    input  logic [7:0]    WR_DATA,
    output logic          TX_FULL,
    output logic [AW:0]   TX_COUNT,
    input  logic          RD_EN,
    output logic [7:0]    RD_DATA,
    output logic          RX_EMPTY,
    output logic [AW:0]   RX_COUNT,
    output logic          BUSY,
    output logic [1:0]    ERR,
    input  logic          ERR_CLR,
    output logic          SPI_WRITE,
    output logic          SPI_READ,
    output logic [7:0]    SPI_TX_DATA,
    input  logic [7:0]    SPI_RX_DATA,
    input  logic [7:0]    SPI_STATUS,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_READ      = 3'd4
    } state_t;

    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [9:0]  TMO_LIMIT = 10'(TIMEOUT);

    state_t        state;
    logic [9:0]    tmo_cnt;
    logic          spi_write_q;
    logic          spi_read_q;
    logic [7:0]    spi_tx_data_q;
    logic [1:0]    err_q;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wptr;
    logic [AW-1:0] tx_rptr;
    logic [AW:0]   tx_cnt;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_push;
    logic          tx_pop;

    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wptr;
    logic [AW-1:0] rx_rptr;
    logic [AW:0]   rx_cnt;
    logic          rx_full;
    logic          rx_empty;
    logic          rx_push;
    logic          rx_pop;

    logic          in_wait;
    logic          tmo_hit;
    logic          unused_status;

    assign unused_status = ^SPI_STATUS[7:2];

    // Host handshake: a WR_EN cycle is accepted iff TX_FULL=0 (else dropped and flagged);
    // an RD_EN cycle consumes RD_DATA iff RX_EMPTY=0 (else ignored). Both act on the same edge.
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = WR_EN && !tx_full;
    assign tx_pop   = (state == S_LOAD);

    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign rx_push  = (state == S_READ);
    assign rx_pop   = RD_EN && !rx_empty;

    assign in_wait  = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign tmo_hit  = in_wait && (tmo_cnt == TMO_LIMIT);

    always_ff @(posedge CLK) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr <= tx_wptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + 1'b1;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= SPI_RX_DATA;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push) begin
                rx_wptr <= rx_wptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + 1'b1;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Launch only with a free RX slot: the host cannot fill RX, so READ always has room.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state         <= S_IDLE;
            tmo_cnt       <= '0;
            spi_write_q   <= 1'b0;
            spi_read_q    <= 1'b0;
            spi_tx_data_q <= '0;
        end else begin
            spi_write_q <= 1'b0;
            spi_read_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!tx_empty && !rx_full && SPI_STATUS[0]) begin
                        state         <= S_LOAD;
                        spi_write_q   <= 1'b1;
                        spi_tx_data_q <= tx_mem[tx_rptr];
                    end
                end
                S_LOAD: begin
                    state   <= S_WAIT_BUSY;
                    tmo_cnt <= '0;
                end
                S_WAIT_BUSY: begin
                    if (tmo_hit) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (!SPI_STATUS[0]) begin
                            state <= S_WAIT_DONE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (tmo_hit) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (SPI_STATUS[1]) begin
                            state      <= S_READ;
                            spi_read_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            err_q <= '0;
        end else begin
            err_q <= (ERR_CLR ? 2'b00 : err_q) | {tmo_hit, WR_EN && tx_full};
        end
    end

    assign TX_FULL     = tx_full;
    assign TX_COUNT    = tx_cnt;
    assign RD_DATA     = rx_mem[rx_rptr];
    assign RX_EMPTY    = rx_empty;
    assign RX_COUNT    = rx_cnt;
    assign BUSY        = (state != S_IDLE);
    assign ERR         = err_q;
    assign SPI_WRITE   = spi_write_q;
    assign SPI_READ    = spi_read_q;
    assign SPI_TX_DATA = spi_tx_data_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_spi_host_fifo.sv
// Directed bench for spi_host_fifo with a behavioural SPI interface model.
module tb_spi_host_fifo;

    logic       clk = 1'b0;
    logic       CLR = 1'b0;
    logic       WR_EN = 1'b0;
    logic [7:0] WR_DATA = '0;
    logic       TX_FULL;
    logic [3:0] TX_COUNT;
    logic       RD_EN = 1'b0;
    logic [7:0] RD_DATA;
    logic       RX_EMPTY;
    logic [3:0] RX_COUNT;
    logic       BUSY;
    logic [1:0] ERR;
    logic       ERR_CLR = 1'b0;
    logic       SPI_WRITE;
    logic       SPI_READ;
    logic [7:0] SPI_TX_DATA;
    logic [7:0] SPI_RX_DATA = '0;
    logic [7:0] SPI_STATUS = 8'h01;
    logic [2:0] dbg_state;

    spi_host_fifo #(.DEPTH(8), .AW(3), .TIMEOUT(1023)) dut (
        .CLK(clk), .CLR(CLR), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
        .TX_FULL(TX_FULL), .TX_COUNT(TX_COUNT), .RD_EN(RD_EN), .RD_DATA(RD_DATA),
        .RX_EMPTY(RX_EMPTY), .RX_COUNT(RX_COUNT), .BUSY(BUSY), .ERR(ERR),
        .ERR_CLR(ERR_CLR), .SPI_WRITE(SPI_WRITE), .SPI_READ(SPI_READ),
        .SPI_TX_DATA(SPI_TX_DATA), .SPI_RX_DATA(SPI_RX_DATA),
        .SPI_STATUS(SPI_STATUS), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- interface model and monitor ----------------
    bit         st0 = 1'b1, st1 = 1'b0;
    bit         stall = 1'b0, hang = 1'b0, const_mode = 1'b0;
    int         shift_cnt = 0;
    logic [7:0] shift_byte = '0;
    int         write_cnt = 0, read_cnt = 0, both_cnt = 0, wr_run = 0, wr_run_max = 0;
    logic [7:0] last_wr = '0;

    always @(negedge clk) begin
        if (!CLR) begin
            st0 = 1'b1;
            st1 = 1'b0;
            shift_cnt = 0;
        end else begin
            if (SPI_WRITE) begin
                shift_byte = SPI_TX_DATA;
                shift_cnt = 3;
                st0 = 1'b0;
            end else if (shift_cnt > 0) begin
                shift_cnt = shift_cnt - 1;
                if (shift_cnt == 0) begin
                    st0 = 1'b1;
                    if (!hang) st1 = 1'b1;
                end
            end
            if (SPI_READ) st1 = 1'b0;
        end
        SPI_STATUS  = {6'b0, st1, st0 & ~stall};
        SPI_RX_DATA = const_mode ? 8'h3C : ~shift_byte;
        if (SPI_WRITE) begin
            write_cnt = write_cnt + 1;
            last_wr = SPI_TX_DATA;
            wr_run = wr_run + 1;
            if (wr_run > wr_run_max) wr_run_max = wr_run;
        end else begin
            wr_run = 0;
        end
        if (SPI_READ) read_cnt = read_cnt + 1;
        if (SPI_WRITE && SPI_READ) both_cnt = both_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            WR_EN = 1'b1;
            WR_DATA = first + 8'(i);
        end
        step();
        WR_EN = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        step();
        e = exp_q.pop_front();
        check(tag, {31'b0, RX_EMPTY}, 32'd0);
        check(tag, {24'b0, RD_DATA}, {24'b0, e});
        RD_EN = 1'b1;
        step();
        RD_EN = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(TX_COUNT == 0 && !BUSY) && n < budget) begin
            step();
            n++;
        end
        check(tag, {31'b0, (n < budget)}, 32'd1);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n = 0;
        while (dbg_state != s && n < budget) begin
            step();
            n++;
        end
        check(tag, {31'b0, (n < budget)}, 32'd1);
    endtask

    // ---------------- directed tests ----------------
    int wr_before, rd_before, busy_cycles, n;

    initial begin
        repeat (3) step();
        // reset values while CLR held low
        check("rst_tx_count", {28'b0, TX_COUNT}, 32'd0);
        check("rst_rx_empty", {31'b0, RX_EMPTY}, 32'd1);
        check("rst_busy", {31'b0, BUSY}, 32'd0);
        check("rst_spi_tx_data", {24'b0, SPI_TX_DATA}, 32'd0);
        CLR = 1'b1;
        step();
        check("rst_tx_full", {31'b0, TX_FULL}, 32'd0);
        check("rst_rx_count", {28'b0, RX_COUNT}, 32'd0);
        check("rst_err", {30'b0, ERR}, 32'd0);
        check("rst_write_read", {30'b0, SPI_WRITE, SPI_READ}, 32'd0);
        check("rst_state", {29'b0, dbg_state}, 32'd0);

        // single byte, interface returns 0x3C
        const_mode = 1'b1;
        push_burst(8'hA5, 1);
        wait_idle("t1_idle", 50);
        check("t1_write_cnt", write_cnt, 32'd1);
        check("t1_write_width", wr_run_max, 32'd1);
        check("t1_tx_byte", {24'b0, last_wr}, 32'hA5);
        check("t1_tx_data_hold", {24'b0, SPI_TX_DATA}, 32'hA5);
        check("t1_rx_count", {28'b0, RX_COUNT}, 32'd1);
        check("t1_busy", {31'b0, BUSY}, 32'd0);
        exp_q.push_back(8'h3C);
        pop_check("t1_rd_data");
        const_mode = 1'b0;

        // two bursts of 8, echo XOR 0xFF, pointers wrap
        push_burst(8'h00, 8);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'hFF - 8'(i));
        wait_idle("t2_idle_a", 300);
        check("t2_rx_count_a", {28'b0, RX_COUNT}, 32'd8);
        for (int i = 0; i < 8; i++) pop_check("t2_rd_a");
        push_burst(8'h10, 8);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'hEF - 8'(i));
        wait_idle("t2_idle_b", 300);
        check("t2_rx_count_b", {28'b0, RX_COUNT}, 32'd8);
        for (int i = 0; i < 8; i++) pop_check("t2_rd_b");
        check("t2_err", {30'b0, ERR}, 32'd0);

        // overflow with the FSM stalled
        stall = 1'b1;
        wr_before = write_cnt;
        push_burst(8'h20, 8);
        check("t3_tx_full", {31'b0, TX_FULL}, 32'd1);
        check("t3_err_before", {30'b0, ERR}, 32'd0);
        push_burst(8'h99, 1);
        check("t3_err_ovf", {30'b0, ERR}, 32'd1);
        check("t3_tx_count", {28'b0, TX_COUNT}, 32'd8);
        check("t3_no_write", write_cnt - wr_before, 32'd0);
        step();
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        check("t3_err_clr", {30'b0, ERR}, 32'd0);
        stall = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'hDF - 8'(i));
        wait_idle("t3_idle", 300);
        check("t3_rx_count", {28'b0, RX_COUNT}, 32'd8);

        // RX full blocks launch until one pop
        wr_before = write_cnt;
        push_burst(8'h30, 1);
        exp_q.push_back(8'hCF);
        repeat (20) step();
        check("t4_no_write", write_cnt - wr_before, 32'd0);
        check("t4_idle", {31'b0, BUSY}, 32'd0);
        check("t4_tx_count", {28'b0, TX_COUNT}, 32'd1);
        pop_check("t4_rd_first");
        wait_idle("t4_idle_after", 50);
        check("t4_launched", write_cnt - wr_before, 32'd1);
        check("t4_rx_count", {28'b0, RX_COUNT}, 32'd8);
        for (int i = 0; i < 8; i++) pop_check("t4_rd");

        // timeout: interface never reports receiver full
        hang = 1'b1;
        rd_before = read_cnt;
        push_burst(8'h40, 1);
        n = 0;
        while (!BUSY && n < 10) begin
            step();
            n++;
        end
        busy_cycles = 0;
        while (BUSY && busy_cycles < 1200) begin
            step();
            busy_cycles++;
        end
        check("t5_tmo_len", {31'b0, (busy_cycles >= 1024 && busy_cycles <= 1026)}, 32'd1);
        check("t5_err", {30'b0, ERR}, 32'd2);
        check("t5_rx_count", {28'b0, RX_COUNT}, 32'd0);
        check("t5_no_read", read_cnt - rd_before, 32'd0);
        check("t5_state", {29'b0, dbg_state}, 32'd0);
        hang = 1'b0;
        step();
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        push_burst(8'h41, 1);
        exp_q.push_back(8'hBE);
        wait_idle("t5_idle", 50);
        check("t5_err_after", {30'b0, ERR}, 32'd0);
        pop_check("t5_rd");

        // asynchronous reset during WAIT_DONE
        hang = 1'b1;
        push_burst(8'h50, 4);
        wait_state("t6_reach_wait_done", 3'd3, 50);
        check("t6_tx_count", {28'b0, TX_COUNT}, 32'd3);
        wr_before = write_cnt;
        rd_before = read_cnt;
        #2;
        CLR = 1'b0;
        #1;
        check("t6_async_tx_count", {28'b0, TX_COUNT}, 32'd0);
        check("t6_async_busy", {31'b0, BUSY}, 32'd0);
        check("t6_async_rx_empty", {31'b0, RX_EMPTY}, 32'd1);
        check("t6_async_spi", {22'b0, SPI_WRITE, SPI_READ, SPI_TX_DATA}, 32'd0);
        check("t6_async_err", {30'b0, ERR}, 32'd0);
        step();
        hang = 1'b0;
        CLR = 1'b1;
        repeat (30) step();
        check("t6_no_read", read_cnt - rd_before, 32'd0);
        check("t6_no_write", write_cnt - wr_before, 32'd0);
        check("t6_rx_count", {28'b0, RX_COUNT}, 32'd0);
        check("t6_tx_count_after", {28'b0, TX_COUNT}, 32'd0);

        check("write_read_overlap", both_cnt, 32'd0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
